// File: rtl/rom_copy_engine.sv
// ROM-to-RAM block copy initiator: one ROM read and one handshaked RAM write per word.
// Range is validated up front so a copy never reads outside the ROM window.
module rom_copy_engine #(
   parameter logic [31:0] ROM_BASE = 32'h0000_0000,
   parameter logic [31:0] ROM_END  = 32'h0000_4000,
   parameter int unsigned LEN_BITS = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [31:0]         src_addr,
   input  logic [31:0]         dst_addr,
   input  logic [LEN_BITS-1:0] len_words,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [31:0]         rom_addr,
   input  logic [31:0]         rom_data,
   output logic                mem_wvalid,
   input  logic                mem_wready,
   output logic [31:0]         mem_waddr,
   output logic [31:0]         mem_wdata
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t              state;
   logic [31:0]         rd_ptr;
   logic [31:0]         wr_ptr;
   logic [LEN_BITS-1:0] remaining;

   logic [31:0] src_al;
   logic [31:0] dst_al;
   logic [32:0] src_end;
   logic [32:0] src_below;
   logic        range_bad;

   // 33-bit arithmetic: carry out of the end sum or borrow below the base both flag a violation.
   always_comb begin
      src_al    = {src_addr[31:2], 2'b00};
      dst_al    = {dst_addr[31:2], 2'b00};
      src_end   = {1'b0, src_al} + {{(31-LEN_BITS){1'b0}}, len_words, 2'b00};
      src_below = {1'b0, src_al} - {1'b0, ROM_BASE};
      range_bad = src_below[32] || (src_end > {1'b0, ROM_END});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         remaining  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         rom_addr   <= '0;
         mem_wvalid <= 1'b0;
         mem_waddr  <= '0;
         mem_wdata  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (len_words == '0) begin
                     err   <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else if (range_bad) begin
                     err   <= 1'b1;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     err       <= 1'b0;
                     rd_ptr    <= src_al;
                     wr_ptr    <= dst_al;
                     remaining <= len_words;
                     rom_addr  <= src_al;
                     busy      <= 1'b1;
                     state     <= READ;
                  end
               end
            end
            READ: begin
               mem_wdata  <= rom_data;
               mem_waddr  <= wr_ptr;
               mem_wvalid <= 1'b1;
               state      <= WRITE;
            end
            WRITE: begin
               if (mem_wready) begin
                  mem_wvalid <= 1'b0;
                  rd_ptr     <= rd_ptr + 32'd4;
                  wr_ptr     <= wr_ptr + 32'd4;
                  remaining  <= remaining - LEN_BITS'(1);
                  if (remaining == LEN_BITS'(1)) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     // rom_addr is registered, so it is loaded with the next pointer on entry to READ
                     rom_addr <= rd_ptr + 32'd4;
                     state    <= READ;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rom_copy_engine.sv
// Self-checking bench for rom_copy_engine: directed scenarios plus randomized copies
// compared against a queue-based reference of the expected write stream.
module tb_rom_copy_engine;

   localparam logic [31:0] ROM_BASE = 32'h0000_0000;
   localparam logic [31:0] ROM_END  = 32'h0000_4000;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] src_addr;
   logic [31:0] dst_addr;
   logic [15:0] len_words;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] rom_addr;
   logic [31:0] rom_data;
   logic        mem_wvalid;
   logic        mem_wready;
   logic [31:0] mem_waddr;
   logic [31:0] mem_wdata;

   always #5 clk = ~clk;

   logic [31:0] rom [0:4095];
   assign rom_data = (rom_addr < ROM_END) ? rom[rom_addr[13:2]] : 32'hBAD0_BAD0;

   rom_copy_engine #(
      .ROM_BASE(ROM_BASE),
      .ROM_END (ROM_END),
      .LEN_BITS(16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .src_addr  (src_addr),
      .dst_addr  (dst_addr),
      .len_words (len_words),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .mem_wvalid(mem_wvalid),
      .mem_wready(mem_wready),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Write capture and protocol checks, sampled mid-cycle
   logic [31:0] cap_a[$];
   logic [31:0] cap_d[$];
   int          done_cnt = 0;
   logic        hold_prev = 1'b0;
   logic [31:0] hold_a, hold_d;

   always @(negedge clk) begin
      chk("rom_addr_align", {30'b0, rom_addr[1:0]}, 32'd0);
      chk("waddr_align", {30'b0, mem_waddr[1:0]}, 32'd0);
      if (busy && !mem_wvalid && !rst)
         chk("rom_in_range", {31'b0, (longint'(rom_addr) >= longint'(ROM_BASE)) && (rom_addr < ROM_END)}, 32'd1);
      if (hold_prev) begin
         chk("hold_wvalid", {31'b0, mem_wvalid}, 32'd1);
         chk("hold_waddr", mem_waddr, hold_a);
         chk("hold_wdata", mem_wdata, hold_d);
      end
      hold_prev = mem_wvalid && !mem_wready && !rst;
      hold_a    = mem_waddr;
      hold_d    = mem_wdata;
      if (mem_wvalid && mem_wready && !rst) begin
         cap_a.push_back(mem_waddr);
         cap_d.push_back(mem_wdata);
      end
      if (done && !rst) done_cnt++;
   end

   // mode 0: wready high, 1: random wready, 2: three-cycle stall on the second word
   task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int unsigned len,
                           input int mode, input int ign_at);
      logic [31:0] s_al, d_al;
      logic [31:0] exp_a[$];
      logic [31:0] exp_d[$];
      longint      e;
      logic        exp_err, copy;
      int          cyc, stall, limit, n;
      s_al    = src & 32'hFFFF_FFFC;
      d_al    = dst & 32'hFFFF_FFFC;
      e       = longint'(s_al) + 4 * longint'(len);
      exp_err = (len != 0) && ((longint'(s_al) < longint'(ROM_BASE)) || (e > longint'(ROM_END)));
      copy    = (len != 0) && !exp_err;
      if (copy)
         for (int unsigned i = 0; i < len; i++) begin
            exp_a.push_back(d_al + 32'(4 * i));
            exp_d.push_back(rom[(s_al >> 2) + i]);
         end
      cap_a.delete();
      cap_d.delete();
      done_cnt   = 0;
      src_addr   = src;
      dst_addr   = dst;
      len_words  = 16'(len);
      start      = 1'b1;
      mem_wready = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", {31'b0, busy}, {31'b0, copy});
      chk("err_after_start", {31'b0, err}, {31'b0, exp_err});
      if (copy) chk("first_rom_addr", rom_addr, s_al);
      cyc   = 1;
      stall = 0;
      limit = 8 * int'(len) + 60;
      while (!done && cyc < limit) begin
         if (cyc == ign_at) begin
            start     = 1'b1;
            src_addr  = src + 32'h40;
            dst_addr  = dst ^ 32'h100;
            len_words = 16'd1;
         end else begin
            start = 1'b0;
         end
         case (mode)
            1: mem_wready = 1'($urandom % 2);
            2: if (cap_a.size() == 1 && mem_wvalid && stall < 3) begin
                  mem_wready = 1'b0;
                  stall++;
               end else begin
                  mem_wready = 1'b1;
               end
            default: mem_wready = 1'b1;
         endcase
         tick();
         cyc++;
      end
      start = 1'b0;
      chk("done_seen", {31'b0, done}, 32'd1);
      if (mode != 1) chk("done_latency", cyc, copy ? 2 * len + 1 + stall : 1);
      chk("err_at_done", {31'b0, err}, {31'b0, exp_err});
      chk("busy_at_done", {31'b0, busy}, 32'd0);
      mem_wready = 1'b1;
      tick();
      chk("done_one_cycle", {31'b0, done}, 32'd0);
      chk("done_count", done_cnt, 32'd1);
      chk("err_sticky", {31'b0, err}, {31'b0, exp_err});
      chk("n_writes", cap_a.size(), exp_a.size());
      n = (cap_a.size() < exp_a.size()) ? cap_a.size() : exp_a.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("waddr[%0d]", i), cap_a[i], exp_a[i]);
         chk($sformatf("wdata[%0d]", i), cap_d[i], exp_d[i]);
      end
   endtask

   initial begin
      int cyc;
      logic [31:0] rs, rd;
      int unsigned rl;
      for (int i = 0; i < 4096; i++) rom[i] = 32'hA000_0000 + 32'(i);
      rst        = 1'b1;
      start      = 1'b0;
      src_addr   = '0;
      dst_addr   = '0;
      len_words  = '0;
      mem_wready = 1'b1;
      tick();
      tick();
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_err", {31'b0, err}, 32'd0);
      chk("rst_wvalid", {31'b0, mem_wvalid}, 32'd0);
      chk("rst_rom_addr", rom_addr, 32'd0);
      chk("rst_waddr", mem_waddr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      rst = 1'b0;
      tick();

      run_copy(32'h0000_0010, 32'h8000_0000, 4, 0, -1);
      run_copy(32'h0000_0010, 32'h8000_0000, 4, 2, -1);
      run_copy(32'h0000_0100, 32'h9000_0000, 0, 0, -1);
      run_copy(32'h0000_3FFC, 32'h8000_0000, 2, 0, -1);
      run_copy(32'h0000_3FF8, 32'h8000_1000, 2, 0, -1);
      run_copy(32'hFFFF_FFFC, 32'h0000_0000, 2, 0, -1);
      run_copy(32'h0000_0020, 32'h8000_2000, 6, 0, 3);

      // Reset while word 2 of 5 is waiting in WRITE
      cap_a.delete();
      cap_d.delete();
      done_cnt  = 0;
      src_addr  = 32'h0000_0040;
      dst_addr  = 32'h8000_3000;
      len_words = 16'd5;
      start     = 1'b1;
      tick();
      start = 1'b0;
      cyc   = 0;
      while (!(cap_a.size() == 2 && mem_wvalid) && cyc < 40) begin
         tick();
         cyc++;
      end
      chk("rst_reached_write", {31'b0, cyc < 40}, 32'd1);
      mem_wready = 1'b0;
      rst        = 1'b1;
      tick();
      chk("midrst_wvalid", {31'b0, mem_wvalid}, 32'd0);
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      chk("midrst_done", {31'b0, done}, 32'd0);
      rst        = 1'b0;
      mem_wready = 1'b1;
      tick();
      tick();
      tick();
      chk("midrst_no_done", done_cnt, 32'd0);
      chk("midrst_writes", cap_a.size(), 32'd2);
      if (cap_a.size() == 2) begin
         chk("midrst_waddr1", cap_a[1], 32'h8000_3004);
         chk("midrst_wdata1", cap_d[1], rom[17]);
      end
      run_copy(32'h0000_0040, 32'h8000_3000, 5, 0, -1);

      run_copy(32'h0000_0013, 32'h8000_0002, 1, 0, -1);

      for (int i = 0; i < 4096; i++) rom[i] = $urandom;
      for (int t = 0; t < 12; t++) begin
         rs = 32'($urandom_range(0, 32'h4040));
         rd = ($urandom % 4 == 0) ? 32'hFFFF_FFF0 + 32'($urandom % 16) : $urandom;
         rl = ($urandom % 6 == 0) ? $urandom_range(4090, 65535) : $urandom_range(0, 10);
         run_copy(rs, rd, rl, int'($urandom % 2), ($urandom % 3 == 0) ? 3 : -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
